// File: rtl/kpn_queue_read_arbiter_if.sv
// Read-side bundle between the KPN queue, its consumer processes and the arbiter.
// KPN_QUEUE_ARB_STATS_EN adds the read/abort statistics counters.
interface kpn_queue_read_arbiter_if #(
  parameter int BITS_NUMBER    = 16,
  parameter int NUM_REQUESTERS = 4
);
  logic [NUM_REQUESTERS-1:0] req;
  logic                      queue_empty;
  logic [BITS_NUMBER-1:0]    queue_data;
  logic                      queue_rd;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [BITS_NUMBER-1:0]    data_out;
  logic [NUM_REQUESTERS-1:0] data_valid;
  logic                      busy;
`ifdef KPN_QUEUE_ARB_STATS_EN
  logic [15:0]               read_count;
  logic [7:0]                abort_count;
`endif

  // master: the arbiter; slave: the queue/consumer side
  modport master (
    input  req, queue_empty, queue_data,
`ifdef KPN_QUEUE_ARB_STATS_EN
    output read_count, abort_count,
`endif
    output queue_rd, grant, data_out, data_valid, busy
  );

  modport slave (
    output req, queue_empty, queue_data,
`ifdef KPN_QUEUE_ARB_STATS_EN
    input  read_count, abort_count,
`endif
    input  queue_rd, grant, data_out, data_valid, busy
  );
endinterface

// File: rtl/kpn_queue_read_arbiter.sv
// Round-robin arbiter sharing one KPN queue read port; each read is IDLE->ISSUE->CAPTURE.
// Optional statistics counters under KPN_QUEUE_ARB_STATS_EN.
module kpn_queue_read_arbiter #(
  parameter int BITS_NUMBER    = 16,
  parameter int NUM_REQUESTERS = 4,
  parameter int REQ_IDX_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  kpn_queue_read_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

  localparam logic [REQ_IDX_BITS-1:0] LAST_IDX = REQ_IDX_BITS'(NUM_REQUESTERS - 1);

  state_e                    state_q, state_d;
  logic [REQ_IDX_BITS-1:0]   last_idx_q, last_idx_d;
  logic [REQ_IDX_BITS-1:0]   win_q, win_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0] dv_q, dv_d;
  logic [BITS_NUMBER-1:0]    dout_q, dout_d;
  logic                      busy_q, busy_d;
`ifdef KPN_QUEUE_ARB_STATS_EN
  logic [15:0]               read_count_q, read_count_d;
  logic [7:0]                abort_count_q, abort_count_d;
`endif

  logic [REQ_IDX_BITS-1:0]   cand, pick;
  logic                      found;

  // Scan upward from last_idx+1, wrapping at NUM_REQUESTERS rather than 2**REQ_IDX_BITS
  always_comb begin
    cand  = last_idx_q;
    pick  = last_idx_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    win_d      = win_q;
    grant_d    = grant_q;
    dv_d       = '0;
    dout_d     = dout_q;
    busy_d     = busy_q;
`ifdef KPN_QUEUE_ARB_STATS_EN
    read_count_d  = read_count_q;
    abort_count_d = abort_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && !bus.queue_empty) begin
          win_d       = pick;
          grant_d     = '0;
          grant_d[pick] = 1'b1;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Queue drained elsewhere: abandon without touching fairness state
        if (bus.queue_empty) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef KPN_QUEUE_ARB_STATS_EN
          if (abort_count_q != 8'hFF) abort_count_d = abort_count_q + 8'd1;
`endif
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        dout_d      = bus.queue_data;
        dv_d[win_q] = 1'b1;
        last_idx_d  = win_q;
        grant_d     = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
`ifdef KPN_QUEUE_ARB_STATS_EN
        read_count_d = read_count_q + 16'd1;
`endif
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_idx_q <= LAST_IDX;
      win_q      <= '0;
      grant_q    <= '0;
      dv_q       <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
`ifdef KPN_QUEUE_ARB_STATS_EN
      read_count_q  <= '0;
      abort_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      win_q      <= win_d;
      grant_q    <= grant_d;
      dv_q       <= dv_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
`ifdef KPN_QUEUE_ARB_STATS_EN
      read_count_q  <= read_count_d;
      abort_count_q <= abort_count_d;
`endif
    end
  end

  // Read strobe is gated by the live empty flag so a late drain never causes an underflow read
  assign bus.queue_rd   = (state_q == ISSUE) && !bus.queue_empty;
  assign bus.grant      = grant_q;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;
  assign bus.busy       = busy_q;
`ifdef KPN_QUEUE_ARB_STATS_EN
  assign bus.read_count  = read_count_q;
  assign bus.abort_count = abort_count_q;
`endif

endmodule
